// File: rtl/conv_pkg.sv
// Shared definitions for the convolution loader and the engine it feeds.
//
// Contents:
//   DATA_W, I_W, K_W  widths shared with the engine top (data_in, I, K)
//   conv_ld_state_t   loader sequencing states
package conv_pkg;

  localparam int DATA_W = 8;   // sample / coefficient width
  localparam int I_W    = 10;  // sample-count config width
  localparam int K_W    = 3;   // tap-count config width

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_H    = 3'd1,
    LOAD_X    = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4
  } conv_ld_state_t;

endpackage

// File: rtl/conv_beat_counter.sv
// Loadable down-counter that tracks the beats still expected in the
// current load phase (taps in LOAD_H, samples in LOAD_X).
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high; clears the count
//   load      in   load count with load_val (takes priority over dec)
//   load_val  in   I_W  value to load
//   dec       in   decrement by one (saturates at zero)
//   count     out  I_W  current count
//   last      out  count == 1, i.e. the next accepted beat is the final one
module conv_beat_counter #(
  parameter int I_W = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [I_W-1:0] load_val,
  input  logic           dec,
  output logic [I_W-1:0] count,
  output logic           last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == I_W'(1));

endmodule

// File: rtl/conv_loader.sv
// Upstream sequencer for the convolution engine. Takes a byte stream of
// cfg_k coefficients followed by cfg_i samples over valid/ready, replays it
// into the engine's serial load interface (load_h phase, then load_x phase),
// pulses start, then waits for done or a timeout.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high; aborts any frame
//   go           in   frame request, sampled in IDLE only
//   cfg_i        in   I_W  sample count, legal 1..2^I_W-1
//   cfg_k        in   K_W  tap count, legal 1..2^K_W-1
//   s_valid      in   upstream byte valid
//   s_ready      out  loader accepts a byte (LOAD_H / LOAD_X only)
//   s_data       in   DATA_W signed upstream byte
//   conv_load_h  out  engine coefficient strobe
//   conv_load_x  out  engine sample strobe
//   conv_data    out  DATA_W signed engine data_in
//   conv_start   out  engine start, one cycle
//   conv_done    in   engine done, honoured in WAIT_DONE only
//   busy         out  any state other than IDLE
//   frame_done   out  one-cycle pulse on normal completion
//   err          out  one-cycle pulse on illegal config or timeout
module conv_loader
  import conv_pkg::*;
#(
  parameter int DATA_W  = conv_pkg::DATA_W,
  parameter int I_W     = conv_pkg::I_W,
  parameter int K_W     = conv_pkg::K_W,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [I_W-1:0]           cfg_i,
  input  logic [K_W-1:0]           cfg_k,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     conv_load_h,
  output logic                     conv_load_x,
  output logic signed [DATA_W-1:0] conv_data,
  output logic                     conv_start,
  input  logic                     conv_done,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err
);

  // Timeout counter only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  conv_ld_state_t state, state_nxt;

  logic [I_W-1:0] cfg_i_q;
  logic           cfg_latch;

  logic           cnt_load;
  logic [I_W-1:0] cnt_val;
  logic           cnt_dec;
  logic [I_W-1:0] beat_cnt;
  logic           beat_last;

  logic [TW-1:0]  tcnt;
  logic           tcnt_clr;
  logic           tcnt_inc;

  logic           accept;
  logic           load_h_nxt;
  logic           load_x_nxt;
  logic           start_nxt;
  logic           frame_done_nxt;
  logic           err_nxt;

  assign s_ready = (state == LOAD_H) || (state == LOAD_X);
  assign accept  = s_valid && s_ready;
  assign busy    = (state != IDLE);

  conv_beat_counter #(
    .I_W(I_W)
  ) u_beat (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .count   (beat_cnt),
    .last    (beat_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next-cycle output strobes.
  always_comb begin
    state_nxt      = state;
    load_h_nxt     = 1'b0;
    load_x_nxt     = 1'b0;
    start_nxt      = 1'b0;
    frame_done_nxt = 1'b0;
    err_nxt        = 1'b0;
    cfg_latch      = 1'b0;
    cnt_load       = 1'b0;
    cnt_val        = I_W'(cfg_k);
    cnt_dec        = 1'b0;
    tcnt_clr       = 1'b0;
    tcnt_inc       = 1'b0;

    case (state)
      IDLE: begin
        if (go) begin
          if ((cfg_k == '0) || (cfg_i == '0)) begin
            err_nxt = 1'b1;
          end else begin
            cfg_latch = 1'b1;
            cnt_load  = 1'b1;
            cnt_val   = I_W'(cfg_k);
            state_nxt = LOAD_H;
          end
        end
      end

      LOAD_H: begin
        if (accept) begin
          load_h_nxt = 1'b1;
          if (beat_last) begin
            // Final tap: rearm the same counter for the sample phase.
            cnt_load  = 1'b1;
            cnt_val   = cfg_i_q;
            state_nxt = LOAD_X;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end

      LOAD_X: begin
        if (accept) begin
          load_x_nxt = 1'b1;
          cnt_dec    = 1'b1;
          if (beat_last) begin
            state_nxt = START;
          end
        end
      end

      // One cycle here lets the final load_x strobe land before start.
      START: begin
        start_nxt = 1'b1;
        tcnt_clr  = 1'b1;
        state_nxt = WAIT_DONE;
      end

      WAIT_DONE: begin
        // done is tested first so it wins against the timeout limit.
        if (conv_done) begin
          frame_done_nxt = 1'b1;
          state_nxt      = IDLE;
        end else if (tcnt == T_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tcnt_inc = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs, config latch and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_load_h <= 1'b0;
      conv_load_x <= 1'b0;
      conv_start  <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      conv_data   <= '0;
      cfg_i_q     <= '0;
      tcnt        <= '0;
    end else begin
      conv_load_h <= load_h_nxt;
      conv_load_x <= load_x_nxt;
      conv_start  <= start_nxt;
      frame_done  <= frame_done_nxt;
      err         <= err_nxt;
      // conv_data only moves on an accept so it holds across bubbles.
      if (accept) begin
        conv_data <= s_data;
      end
      if (cfg_latch) begin
        cfg_i_q <= cfg_i;
      end
      if (tcnt_clr) begin
        tcnt <= '0;
      end else if (tcnt_inc) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/conv_loader.md
Name: conv_loader

Overview:
Upstream sequencer for the convolution engine. It accepts a byte stream of coefficients followed by samples over a valid/ready handshake. It replays that stream into the engine's serial load interface (load_h phase, then load_x phase), pulses start, waits for done, and reports completion or timeout. This is the only block that drives the engine's load_h, load_x, start and data_in inputs.

Parameters:
DATA_W, 8, sample/coefficient width (matches engine data_in)
I_W, 10, width of sample-count config (matches engine I)
K_W, 3, width of tap-count config (matches engine K)
TIMEOUT, 4096, max cycles in WAIT_DONE before error

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
go  in  1  one-cycle request to start a frame (sampled in IDLE only)
cfg_i  in  I_W  number of samples, legal 1..1023
cfg_k  in  K_W  number of taps, legal 1..7
s_valid  in  1  upstream byte valid
s_ready  out  1  loader can accept byte
s_data  in  DATA_W signed  upstream byte
conv_load_h  out  1  to engine load_h
conv_load_x  out  1  to engine load_x
conv_data  out  DATA_W signed  to engine data_in
conv_start  out  1  to engine start
conv_done  in  1  from engine done
busy  out  1  high in any state but IDLE
frame_done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on illegal config or timeout

Behaviour:
- Reset: state=IDLE. All outputs are 0, including s_ready, conv_*, busy, frame_done, err and conv_data. Counters are cleared. Reset mid-frame aborts immediately; no start is issued.
- States: IDLE, LOAD_H, LOAD_X, START, WAIT_DONE.
- IDLE + go:
  - If cfg_k==0 or cfg_i==0: err=1 next cycle, stay IDLE.
  - Otherwise: latch cfg_i/cfg_k, load the beat counter with cfg_k, next state LOAD_H.
- go outside IDLE is ignored; the latched config does not change mid-frame.
- s_ready=1 only in LOAD_H and LOAD_X. It is combinational from state, never from s_valid.
- Accept = s_valid && s_ready.
- Output registration: on an accept, conv_data<=s_data next cycle and the phase strobe is 1 for exactly that cycle:
  - LOAD_H accept drives conv_load_h.
  - LOAD_X accept drives conv_load_x.
- Bubbles (s_valid=0): strobe low that cycle, conv_data holds its last value. The engine advances only on strobe-high cycles.
- conv_load_h and conv_load_x are never high together.
- Beat counter decrements per accept.
  - Accepting the last tap (count==1 in LOAD_H): reload with cfg_i, next state LOAD_X.
  - Accepting the last sample: next state START.
- Exactly cfg_k strobes of conv_load_h and cfg_i strobes of conv_load_x are produced per frame.
- START: conv_start=1 for exactly one cycle. It is asserted one cycle after the final conv_load_x strobe (i.e. 2 cycles after the last accept). Next state WAIT_DONE; timeout counter cleared.
- WAIT_DONE:
  - conv_done sampled high: frame_done=1 next cycle, state to IDLE.
  - Else the timeout counter increments. On reaching TIMEOUT-1 without done: err=1 next cycle, state to IDLE.
  - If done arrives in the same cycle as the timeout limit, done wins.
- conv_done outside WAIT_DONE is ignored.
- busy=1 from the cycle after an accepted go through WAIT_DONE. It falls in the same cycle frame_done or err pulses.
- Counter width is I_W; cfg_i=1023 must not wrap.

Decomposition:
- conv_pkg:
  - state enum conv_ld_state_t {IDLE, LOAD_H, LOAD_X, START, WAIT_DONE}
  - localparams DATA_W, I_W, K_W shared with the engine top
- Sub-module conv_beat_counter: loadable I_W down-counter with a load value, a dec enable and a last flag (count==1). Instantiated once for beats; the timeout counter stays inline.

Test Plan:
- cfg_k=3, cfg_i=5, go, s_valid held high with bytes 1..8 -> conv_load_h high on 3 consecutive cycles with data 1,2,3. Then conv_load_x on 5 cycles with data 4..8. Then conv_start 1 cycle; conv_done pulse 10 cycles later -> frame_done pulse, busy low.
- Same config, s_valid toggled 1,0,1,0 -> strobes only on accepted beats, conv_data holds during gaps, strobe counts still 3/5, no start before the 8th accept.
- go with cfg_k=0 (cfg_i=4), and separately cfg_i=0 -> err pulse 1 cycle later, busy stays 0, no conv_* activity.
- cfg_k=1, cfg_i=1, conv_done never asserted with TIMEOUT=16 -> err exactly 16 cycles after conv_start deasserts, state IDLE; a later frame then completes normally.
- reset asserted during LOAD_X after 2 of 5 samples -> next cycle all outputs 0, s_ready 0; a new go with cfg_k=2, cfg_i=2 runs a clean full frame.
- go pulsed again during WAIT_DONE with different cfg -> ignored; the frame completes with the original counts, and the following go uses the new cfg.
